garegga_prog_packer: RTL and testbench
======================================

GAREGGA_PROG_PACKER -- requirements
Module: garegga_prog_packer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8: word FIFO entries, power of two, 2..64.
REQ-002 SHALL have ports:
- CLK  in  1  sole clock.
- RESET_N  in  1  reset, synchronous, active-low.
- DOWNLOADING  in  1  ROM download window.
- IN_WR  in  1  one-cycle byte strobe.
- IN_ADDR  in  23  region-relative byte address.
- IN_BA  in  2  target SDRAM bank.
- IN_DATA  in  8  byte.
- PROG_ADDR  out  22  word address (IN_ADDR[22:1]).
- PROG_DATA  out  16  [15:8]=even byte, [7:0]=odd byte.
- PROG_MASK  out  2  1=lane not written; [1]=upper lane.
- PROG_BA  out  2  bank.
- PROG_WE  out  1  write request.
- PROG_RDY  in  1  SDRAM write accepted.
- BUSY  out  1  loader activity.
- OVERFLOW  out  1  sticky byte-drop flag.
- CHKSUM  out  16  byte sum (see Configuration).

Function
REQ-003 SHALL keep one byte hold register (valid, addr, ba, data).
REQ-004 SHALL merge an IN_WR odd byte into a valid held even byte of equal IN_ADDR[22:1] and IN_BA, pushing one FIFO entry with MASK=00 and clearing hold.
REQ-005 SHALL, on IN_WR with non-partner hold valid, push held byte alone (even: MASK=01, odd: MASK=10, byte replicated on both lanes) and load new byte into hold.
REQ-006 SHALL load IN_WR byte into empty hold without push.
REQ-007 SHALL flush a valid hold as single-byte entry on the cycle after DOWNLOADING falls.
REQ-008 SHALL push at most one entry per cycle; entry visible at FIFO head the cycle after push.
REQ-009 SHALL drop the pushed entry and set OVERFLOW when FIFO full at push time; hold update still occurs; simultaneous pop frees no space that cycle.
REQ-010 SHALL run issue FSM IDLE -> ISSUE -> GAP -> IDLE/ISSUE:
- IDLE: FIFO non-empty -> ISSUE next cycle.
- ISSUE: PROG_WE=1, head fields stable; PROG_RDY=1 -> pop, GAP.
- GAP: PROG_WE=0 exactly one cycle; FIFO non-empty -> ISSUE, else IDLE.
REQ-011 SHALL give minimum latency 2 cycles from completing IN_WR (merge or push) to PROG_WE high, when IDLE with empty FIFO.
REQ-012 SHALL never deassert PROG_WE in ISSUE before PROG_RDY, including after DOWNLOADING falls.
REQ-013 SHALL drive BUSY = DOWNLOADING | hold valid | FIFO non-empty | state!=IDLE.
REQ-014 SHALL ignore IN_WR while DOWNLOADING=0.
REQ-015 SHALL ignore PROG_RDY outside ISSUE.

Reset
REQ-016 SHALL, with RESET_N=0 at CLK edge, clear hold, FIFO pointers, OVERFLOW, CHKSUM; enter IDLE; drive PROG_WE=0, PROG_ADDR=0, PROG_DATA=0, PROG_MASK=11, PROG_BA=0.
REQ-017 SHALL discard in-flight entries on reset mid-transfer; no PROG_WE before new input after reset release.

Configuration
REQ-018 SHALL, with GAREGGA_PROG_CHKSUM_EN defined, drive CHKSUM = mod-2^16 sum of accepted (non-dropped) IN_DATA bytes, cleared on DOWNLOADING rising edge, held after download.
REQ-019 SHALL, without GAREGGA_PROG_CHKSUM_EN, drive CHKSUM=0 and synthesize no adder.

Structure
REQ-020 SHALL place entry typedef (addr22, data16, mask2, ba2), FSM state enum and width localparams in shared package garegga_pkg.
REQ-021 SHALL instantiate sub-module garegga_prog_fifo (synchronous FIFO, full/empty, parameter FIFO_DEPTH).

Verification
REQ-022 Bytes 0xAB@0x000010, 0xCD@0x000011, BA=1, PROG_RDY=1 -> one write ADDR=0x000008, DATA=0xABCD, MASK=00, BA=1, WE high 2 cycles after second strobe.
REQ-023 Byte 0x5A@0x000020 then 0x77@0x000030 -> first entry ADDR=0x000010, DATA=0x5A5A, MASK=01; DOWNLOADING falls -> ADDR=0x000018, DATA=0x7777, MASK=01.
REQ-024 PROG_RDY held 0 for 20 cycles, 20 merged word pairs -> 8 entries kept (FIFO_DEPTH=8), OVERFLOW=1, WE stable; RDY=1 -> 8 writes, each separated by one WE-low cycle.
REQ-025 RESET_N=0 during ISSUE with 3 entries queued -> next cycle WE=0, MASK=11, BUSY=DOWNLOADING, OVERFLOW=0; no writes follow.
REQ-026 With GAREGGA_PROG_CHKSUM_EN, bytes 0xFF x 300 -> CHKSUM=0x2AD4; new download start -> CHKSUM=0; without macro CHKSUM=0 throughout.

Source files
------------

// File: rtl/garegga_pkg.sv
// Shared types for the Garegga program-ROM packer: the FIFO entry layout,
// the issue FSM state encoding, bus widths and the byte-lane mask codes.
package garegga_pkg;

  localparam int IN_ADDR_W   = 23;
  localparam int PROG_ADDR_W = 22;
  localparam int PROG_DATA_W = 16;
  localparam int BYTE_W      = 8;
  localparam int MASK_W      = 2;
  localparam int BA_W        = 2;

  // Mask bit = 1 means that byte lane is NOT written; bit 1 is the upper lane.
  localparam logic [MASK_W-1:0] MASK_NONE = 2'b11;
  localparam logic [MASK_W-1:0] MASK_BOTH = 2'b00;
  localparam logic [MASK_W-1:0] MASK_EVEN = 2'b01;
  localparam logic [MASK_W-1:0] MASK_ODD  = 2'b10;

  typedef struct packed {
    logic [PROG_ADDR_W-1:0] addr;
    logic [PROG_DATA_W-1:0] data;
    logic [MASK_W-1:0]      mask;
    logic [BA_W-1:0]        ba;
  } prog_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } issue_state_t;

  // A lone byte goes out replicated on both lanes; only its own lane is enabled.
  function automatic prog_entry_t single_entry(input logic [IN_ADDR_W-1:0] byte_addr,
                                               input logic [BA_W-1:0]      bank,
                                               input logic [BYTE_W-1:0]    byte_val);
    prog_entry_t e;
    e.addr = byte_addr[IN_ADDR_W-1:1];
    e.data = {byte_val, byte_val};
    e.mask = byte_addr[0] ? MASK_ODD : MASK_EVEN;
    e.ba   = bank;
    return e;
  endfunction

endpackage

// File: rtl/garegga_prog_packer_if.sv
// SDRAM program-write bus of the packer.
// Handshake: the master raises prog_we with stable prog_addr/data/mask/ba and
// holds everything until a cycle with prog_rdy=1; that cycle is the transfer.
interface garegga_prog_packer_if;
  import garegga_pkg::*;

  logic [PROG_ADDR_W-1:0] prog_addr;
  logic [PROG_DATA_W-1:0] prog_data;
  logic [MASK_W-1:0]      prog_mask;
  logic [BA_W-1:0]        prog_ba;
  logic                   prog_we;
  logic                   prog_rdy;

  modport master (output prog_addr, prog_data, prog_mask, prog_ba, prog_we,
                  input  prog_rdy);
  modport slave  (input  prog_addr, prog_data, prog_mask, prog_ba, prog_we,
                  output prog_rdy);
endinterface

// File: rtl/garegga_prog_fifo.sv
// Synchronous word FIFO for packed program entries. A push while full is
// discarded even if a pop happens in the same cycle. Head is the read-pointer
// entry, valid whenever empty is low.
module garegga_prog_fifo
  import garegga_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  prog_entry_t push_data,
  input  logic        pop,
  output prog_entry_t head,
  output logic        full,
  output logic        empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  prog_entry_t      mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr[PTR_W-1:0]];

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{PTR_W{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{PTR_W{1'b0}}, 1'b1};
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/garegga_prog_packer.sv
// Garegga program-ROM packer: pairs downloaded bytes into 16-bit SDRAM words,
// queues them and issues them with a WE/RDY handshake (one idle cycle between
// writes). Optional byte checksum: define GAREGGA_PROG_CHKSUM_EN.
module garegga_prog_packer
  import garegga_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   DOWNLOADING,
  input  logic                   IN_WR,
  input  logic [IN_ADDR_W-1:0]   IN_ADDR,
  input  logic [BA_W-1:0]        IN_BA,
  input  logic [BYTE_W-1:0]      IN_DATA,
  output logic [PROG_ADDR_W-1:0] PROG_ADDR,
  output logic [PROG_DATA_W-1:0] PROG_DATA,
  output logic [MASK_W-1:0]      PROG_MASK,
  output logic [BA_W-1:0]        PROG_BA,
  output logic                   PROG_WE,
  input  logic                   PROG_RDY,
  output logic                   BUSY,
  output logic                   OVERFLOW,
  output logic [PROG_DATA_W-1:0] CHKSUM
);

  logic                 hold_valid;
  logic [IN_ADDR_W-1:0] hold_addr;
  logic [BA_W-1:0]      hold_ba;
  logic [BYTE_W-1:0]    hold_data;
  logic                 dl_q;

  logic                 wr_acc;
  logic                 dl_fall;
  logic                 partner;
  logic                 push;
  prog_entry_t          push_entry;
  logic                 hold_load;
  logic                 hold_clear;
  logic                 pop;
  prog_entry_t          head;
  logic                 fifo_full;
  logic                 fifo_empty;

  issue_state_t         state;
  issue_state_t         state_next;

  assign wr_acc  = IN_WR & DOWNLOADING;
  assign dl_fall = dl_q & ~DOWNLOADING;
  assign partner = hold_valid & ~hold_addr[0] & IN_ADDR[0] &
                   (hold_addr[IN_ADDR_W-1:1] == IN_ADDR[IN_ADDR_W-1:1]) &
                   (hold_ba == IN_BA);

  // Byte pairing: merge an odd partner, else evict the held byte alone.
  always_comb begin
    push       = 1'b0;
    push_entry = single_entry(hold_addr, hold_ba, hold_data);
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    if (wr_acc) begin
      if (partner) begin
        push            = 1'b1;
        push_entry.addr = hold_addr[IN_ADDR_W-1:1];
        push_entry.data = {hold_data, IN_DATA};
        push_entry.mask = MASK_BOTH;
        push_entry.ba   = hold_ba;
        hold_clear      = 1'b1;
      end else begin
        push      = hold_valid;
        hold_load = 1'b1;
      end
    end else if (dl_fall && hold_valid) begin
      push       = 1'b1;
      hold_clear = 1'b1;
    end
  end

  // Byte hold register.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      hold_valid <= 1'b0;
      hold_addr  <= '0;
      hold_ba    <= '0;
      hold_data  <= '0;
    end else if (hold_load) begin
      hold_valid <= 1'b1;
      hold_addr  <= IN_ADDR;
      hold_ba    <= IN_BA;
      hold_data  <= IN_DATA;
    end else if (hold_clear) begin
      hold_valid <= 1'b0;
    end
  end

  // Download-window edge tracking and sticky drop flag.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      dl_q     <= 1'b0;
      OVERFLOW <= 1'b0;
    end else begin
      dl_q <= DOWNLOADING;
      if (push && fifo_full) OVERFLOW <= 1'b1;
    end
  end

  garegga_prog_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Issue FSM state register.
  always_ff @(posedge CLK) begin
    if (!RESET_N) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Issue FSM: hold WE until RDY, then one forced low cycle before the next word.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      ST_IDLE:  if (!fifo_empty) state_next = ST_ISSUE;
      ST_ISSUE: begin
        if (PROG_RDY) begin
          pop        = 1'b1;
          state_next = ST_GAP;
        end
      end
      ST_GAP:   state_next = fifo_empty ? ST_IDLE : ST_ISSUE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Bus outputs: head fields only while issuing, idle pattern otherwise.
  always_comb begin
    PROG_WE   = 1'b0;
    PROG_ADDR = '0;
    PROG_DATA = '0;
    PROG_MASK = MASK_NONE;
    PROG_BA   = '0;
    if (state == ST_ISSUE) begin
      PROG_WE   = 1'b1;
      PROG_ADDR = head.addr;
      PROG_DATA = head.data;
      PROG_MASK = head.mask;
      PROG_BA   = head.ba;
    end
  end

  assign BUSY = DOWNLOADING | hold_valid | ~fifo_empty | (state != ST_IDLE);

`ifdef GAREGGA_PROG_CHKSUM_EN
  logic [PROG_DATA_W-1:0] push_sum;
  logic [PROG_DATA_W-1:0] chk_q;
  logic                   accept;
  logic                   dl_rise;

  assign accept  = push & ~fifo_full;
  assign dl_rise = DOWNLOADING & ~dl_q;

  // Bytes carried by the entry being pushed (a merge carries two).
  always_comb begin
    push_sum = PROG_DATA_W'(hold_data);
    if (wr_acc && partner) push_sum = PROG_DATA_W'(hold_data) + PROG_DATA_W'(IN_DATA);
  end

  // Running sum of bytes that actually entered the FIFO; restarts per download.
  always_ff @(posedge CLK) begin
    if (!RESET_N)     chk_q <= '0;
    else if (dl_rise) chk_q <= accept ? push_sum : '0;
    else if (accept)  chk_q <= chk_q + push_sum;
  end

  assign CHKSUM = chk_q;
`else
  assign CHKSUM = '0;
`endif

endmodule

// File: tb/tb_garegga_prog_packer.sv
// Bench for garegga_prog_packer: directed scenarios plus randomized bursts,
// all writes scored against a byte-level reference model.
module tb_garegga_prog_packer;
  import garegga_pkg::*;

  localparam int FIFO_DEPTH = 8;
  localparam int ENTRY_W    = $bits(prog_entry_t);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        downloading;
  logic        in_wr;
  logic [22:0] in_addr;
  logic [1:0]  in_ba;
  logic [7:0]  in_data;
  logic        busy;
  logic        overflow;
  logic [15:0] chksum;

  garegga_prog_packer_if pif ();

  garegga_prog_packer #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .CLK         (clk),
    .RESET_N     (rst_n),
    .DOWNLOADING (downloading),
    .IN_WR       (in_wr),
    .IN_ADDR     (in_addr),
    .IN_BA       (in_ba),
    .IN_DATA     (in_data),
    .PROG_ADDR   (pif.prog_addr),
    .PROG_DATA   (pif.prog_data),
    .PROG_MASK   (pif.prog_mask),
    .PROG_BA     (pif.prog_ba),
    .PROG_WE     (pif.prog_we),
    .PROG_RDY    (pif.prog_rdy),
    .BUSY        (busy),
    .OVERFLOW    (overflow),
    .CHKSUM      (chksum)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard and reference model ----------------
  logic [ENTRY_W-1:0] exp_q[$];
  logic        m_hv = 1'b0;
  logic [22:0] m_ha;
  logic [1:0]  m_hb;
  logic [7:0]  m_hd;
  logic        exp_ovf = 1'b0;
  logic [15:0] exp_sum = '0;

  int n_checks = 0;
  int n_err    = 0;
  logic mon_en = 1'b0;
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [ENTRY_W-1:0] mk_entry(input logic [22:0] a, input logic [1:0] ba,
                                                 input logic [7:0] hi, input logic [7:0] lo,
                                                 input logic [1:0] mask);
    logic [21:0] waddr;
    waddr = 22'(a >> 1);
    return {waddr, hi, lo, mask, ba};
  endfunction

  // An entry is lost when the queue already holds FIFO_DEPTH words at push time.
  task automatic model_push(input logic [ENTRY_W-1:0] e, input int byte_sum);
    if (exp_q.size() >= FIFO_DEPTH) begin
      exp_ovf = 1'b1;
    end else begin
      exp_q.push_back(e);
      exp_sum = exp_sum + 16'(byte_sum);
    end
  endtask

  task automatic model_single();
    if (m_ha % 2 == 0) model_push(mk_entry(m_ha, m_hb, m_hd, m_hd, 2'b01), int'(m_hd));
    else               model_push(mk_entry(m_ha, m_hb, m_hd, m_hd, 2'b10), int'(m_hd));
  endtask

  task automatic model_byte(input logic [22:0] a, input logic [1:0] ba, input logic [7:0] d);
    if (!downloading) return;
    if (m_hv && (m_ha % 2 == 0) && (a % 2 == 1) && (m_ha / 2 == a / 2) && (m_hb == ba)) begin
      model_push(mk_entry(a, ba, m_hd, d, 2'b00), int'(m_hd) + int'(d));
      m_hv = 1'b0;
    end else begin
      if (m_hv) model_single();
      m_hv = 1'b1;
      m_ha = a;
      m_hb = ba;
      m_hd = d;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [22:0] a, input logic [1:0] ba, input logic [7:0] d);
    in_wr   = 1'b1;
    in_addr = a;
    in_ba   = ba;
    in_data = d;
    model_byte(a, ba, d);
    tick();
    in_wr = 1'b0;
  endtask

  task automatic start_dl();
    downloading = 1'b1;
    exp_sum     = '0;
    tick();
  endtask

  task automatic end_dl();
    downloading = 1'b0;
    if (m_hv) model_single();
    m_hv = 1'b0;
    tick();
  endtask

  task automatic wait_drain(input string tag, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    repeat (3) tick();
    check_eq(tag, 64'(exp_q.size()), 64'd0);
  endtask

  // Returns at the falling edge of the first cycle with PROG_WE high.
  task automatic wait_we(input string tag, input int bound);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      sample();
      if (pif.prog_we) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    if (!seen) check_eq(tag, 64'(pif.prog_we), 64'd1);
  endtask

  // ---------------- ready driver ----------------
  initial begin
    pif.prog_rdy = 1'b0;
    forever begin
      tick();
      case (rdy_mode)
        0:       pif.prog_rdy = 1'b1;
        1:       pif.prog_rdy = 1'($urandom_range(0, 1));
        default: pif.prog_rdy = 1'b0;
      endcase
    end
  end

  // ---------------- bus monitor ----------------
  initial begin
    logic               prev_we;
    logic               prev_rdy;
    logic               prev_hs;
    logic               hs;
    logic [ENTRY_W-1:0] prev_fields;
    logic [ENTRY_W-1:0] cur;
    prev_we = 1'b0; prev_rdy = 1'b0; prev_hs = 1'b0; prev_fields = '0;
    forever begin
      sample();
      if (!rst_n || !mon_en) begin
        prev_we = 1'b0; prev_rdy = 1'b0; prev_hs = 1'b0;
        continue;
      end
      cur = {pif.prog_addr, pif.prog_data, pif.prog_mask, pif.prog_ba};
      if (prev_we && !prev_rdy) begin
        check_eq("we_held", 64'(pif.prog_we), 64'd1);
        check_eq("fields_stable", 64'(cur), 64'(prev_fields));
      end
      if (prev_hs) check_eq("gap_low", 64'(pif.prog_we), 64'd0);
      hs = pif.prog_we && pif.prog_rdy;
      if (hs) begin
        if (exp_q.size() == 0) check_eq("unexpected_write_qsize", 64'(exp_q.size()), 64'd1);
        else                   check_eq("write", 64'(cur), 64'(exp_q.pop_front()));
      end
      prev_we = pif.prog_we; prev_rdy = pif.prog_rdy; prev_fields = cur; prev_hs = hs;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int last_hs;
    int n_hs;
    logic [22:0] base;
    logic [22:0] a;
    logic [7:0]  d0;
    logic [7:0]  d1;
    int nb;
    int pat;

    rst_n = 1'b0; downloading = 1'b0; in_wr = 1'b0;
    in_addr = '0; in_ba = '0; in_data = '0;
    repeat (3) tick();
    sample();
    check_eq("rst_we",   64'(pif.prog_we),   64'd0);
    check_eq("rst_addr", 64'(pif.prog_addr), 64'd0);
    check_eq("rst_data", 64'(pif.prog_data), 64'd0);
    check_eq("rst_mask", 64'(pif.prog_mask), 64'h3);
    check_eq("rst_ba",   64'(pif.prog_ba),   64'd0);
    check_eq("rst_busy", 64'(busy),          64'd0);
    check_eq("rst_ovf",  64'(overflow),      64'd0);
    check_eq("rst_chk",  64'(chksum),        64'd0);
    tick();
    rst_n  = 1'b1;
    mon_en = 1'b1;
    rdy_mode = 0;
    tick();

    // Merge of an even/odd pair and the two-cycle issue latency.
    start_dl();
    send_byte(23'h000010, 2'd1, 8'hAB);
    send_byte(23'h000011, 2'd1, 8'hCD);
    sample();
    check_eq("r22_we_early", 64'(pif.prog_we), 64'd0);
    tick();
    sample();
    check_eq("r22_we",   64'(pif.prog_we),   64'd1);
    check_eq("r22_addr", 64'(pif.prog_addr), 64'h000008);
    check_eq("r22_data", 64'(pif.prog_data), 64'hABCD);
    check_eq("r22_mask", 64'(pif.prog_mask), 64'd0);
    check_eq("r22_ba",   64'(pif.prog_ba),   64'd1);
    tick();
    wait_drain("r22_drain", 50);

    // Unpaired bytes: eviction and flush at end of download.
    send_byte(23'h000020, 2'd0, 8'h5A);
    send_byte(23'h000030, 2'd0, 8'h77);
    wait_we("r23_a_timeout", 20);
    check_eq("r23_a_addr", 64'(pif.prog_addr), 64'h000010);
    check_eq("r23_a_data", 64'(pif.prog_data), 64'h5A5A);
    check_eq("r23_a_mask", 64'(pif.prog_mask), 64'h1);
    tick();
    end_dl();
    wait_we("r23_b_timeout", 20);
    check_eq("r23_b_addr", 64'(pif.prog_addr), 64'h000018);
    check_eq("r23_b_data", 64'(pif.prog_data), 64'h7777);
    check_eq("r23_b_mask", 64'(pif.prog_mask), 64'h1);
    tick();
    wait_drain("r23_drain", 50);
    send_byte(23'h000040, 2'd0, 8'h99);  // ignored: no download window
    repeat (3) tick();
    sample();
    check_eq("r14_busy_idle", 64'(busy), 64'd0);
    tick();

    // Stalled sink: only FIFO_DEPTH words survive, then one gap cycle between writes.
    start_dl();
    rdy_mode = 2;
    pif.prog_rdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      d0 = 8'($urandom); d1 = 8'($urandom);
      send_byte(23'h001000 + 23'(2 * i), 2'd2, d0);
      send_byte(23'h001001 + 23'(2 * i), 2'd2, d1);
    end
    sample();
    check_eq("r24_ovf", 64'(overflow), 64'(exp_ovf));
    check_eq("r24_we_stalled", 64'(pif.prog_we), 64'd1);
    tick();
    rdy_mode = 0;
    pif.prog_rdy = 1'b1;
    last_hs = -1;
    n_hs = 0;
    for (int i = 0; i < 60; i++) begin
      sample();
      if (pif.prog_we && pif.prog_rdy) begin
        if (last_hs >= 0) check_eq("r24_spacing", 64'(cyc - last_hs), 64'd2);
        last_hs = cyc;
        n_hs++;
      end
      tick();
    end
    check_eq("r24_writes", 64'(n_hs), 64'(FIFO_DEPTH));
    wait_drain("r24_drain", 50);

    // Reset while issuing with words queued: everything in flight is discarded.
    rdy_mode = 2;
    pif.prog_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_byte(23'h002000 + 23'(2 * i), 2'd3, 8'($urandom));
      send_byte(23'h002001 + 23'(2 * i), 2'd3, 8'($urandom));
    end
    sample();
    check_eq("r25_issue",   64'(pif.prog_we), 64'd1);
    check_eq("r25_ovf_pre", 64'(overflow),    64'(exp_ovf));
    tick();
    rst_n = 1'b0;
    exp_q.delete();
    m_hv = 1'b0; exp_ovf = 1'b0; exp_sum = '0;
    tick();
    rst_n = 1'b1;
    sample();
    check_eq("r25_we",   64'(pif.prog_we),   64'd0);
    check_eq("r25_mask", 64'(pif.prog_mask), 64'h3);
    check_eq("r25_busy", 64'(busy),          64'(downloading));
    check_eq("r25_ovf",  64'(overflow),      64'd0);
    tick();
    rdy_mode = 0;
    repeat (20) tick();
    end_dl();
    sample();
    check_eq("r25_busy_end", 64'(busy), 64'd0);
    tick();

    // Checksum over 300 x 0xFF, held after the window, cleared on the next one.
    start_dl();
    for (int i = 0; i < 300; i++) send_byte(23'h004000 + 23'(i), 2'd3, 8'hFF);
    end_dl();
    wait_drain("r26_drain", 100);
    sample();
    check_eq("r26_ovf", 64'(overflow), 64'(exp_ovf));
`ifdef GAREGGA_PROG_CHKSUM_EN
    check_eq("r26_chk", 64'(chksum), 64'h2AD4);
`else
    check_eq("r26_chk", 64'(chksum), 64'd0);
`endif
    tick();
    repeat (5) tick();
    sample();
`ifdef GAREGGA_PROG_CHKSUM_EN
    check_eq("r26_chk_held", 64'(chksum), 64'(exp_sum));
`else
    check_eq("r26_chk_held", 64'(chksum), 64'd0);
`endif
    tick();
    start_dl();
    sample();
    check_eq("r26_chk_clear", 64'(chksum), 64'd0);
    tick();

    // Randomized bursts, each at most FIFO_DEPTH strobes from a drained queue.
    for (int b = 0; b < 40; b++) begin
      if (!downloading) start_dl();
      rdy_mode = int'($urandom_range(0, 1));
      nb   = int'($urandom_range(1, 8));
      pat  = int'($urandom_range(0, 3));
      base = 23'($urandom) & 23'h7FFFF0;
      for (int j = 0; j < nb; j++) begin
        case (pat)
          0:       a = base + 23'(j);
          1:       a = 23'($urandom);
          2:       a = base + 23'(15 - j);
          default: a = base + 23'(j);
        endcase
        send_byte(a, (pat == 3) ? 2'($urandom_range(0, 3)) : 2'd1, 8'($urandom));
        if ($urandom_range(0, 3) == 0) tick();
      end
      if ($urandom_range(0, 3) == 0) begin
        end_dl();
        send_byte(23'($urandom), 2'd0, 8'($urandom));
      end
      rdy_mode = 0;
      wait_drain("rand_drain", 200);
      sample();
      check_eq("rand_ovf", 64'(overflow), 64'(exp_ovf));
`ifdef GAREGGA_PROG_CHKSUM_EN
      check_eq("rand_chk", 64'(chksum), 64'(exp_sum));
`else
      check_eq("rand_chk", 64'(chksum), 64'd0);
`endif
      if (!downloading) check_eq("rand_busy", 64'(busy), 64'd0);
      tick();
    end

    if (downloading) end_dl();
    wait_drain("final_drain", 100);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
